song_sequencer: RTL
===================

Name: song_sequencer

Overview:
Parametrised auto-play note sequencer: steps through a packed song of NOTE_W-bit note codes and drives the buzzer note input.
- Adds start/pause/stop control, runtime song length, optional looping, position readout and a done pulse.
- Sits between the song library (packed song bus) and the buzzer driver; intended replacement for the fixed 28-note, 4-bit, free-running auto mode.

Parameters:
NOTE_W, 4, bits per note code; code 0 = rest.
SONG_LEN, 28, max notes in packed song bus.
NOTE_TICKS, 500000, clk cycles each note is held; must be >= 2.
POS_W, 5, width of position/length fields; must satisfy 2^POS_W >= SONG_LEN+1.
GAP_TICKS, 50000, rest cycles between notes; used only with NOTE_GAP_EN; must be >= 1.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  reset, asynchronous, active-low.
start  input  1  level; sampled each edge; begins playback from IDLE, resumes from PAUSE.
pause  input  1  level; freezes playback in PLAY.
stop  input  1  level; aborts to IDLE from any state.
loop_en  input  1  1 = restart at note 0 after last note; 0 = finish.
song_length  input  POS_W  notes to play; 0 = invalid; values > SONG_LEN clamp to SONG_LEN.
song_packed  input  NOTE_W*SONG_LEN  note i at bits [NOTE_W*i +: NOTE_W].
note_to_play  output  NOTE_W  registered note code to buzzer.
position  output  POS_W  index of current note.
playing  output  1  high in PLAY (and GAP).
done  output  1  one-cycle pulse when a non-looping song ends.

Behaviour:
- Reset (async assert, sync release): state IDLE, note_to_play 0, position 0, tick counter 0, playing 0, done 0.
- States: IDLE, PLAY, PAUSE (plus GAP with NOTE_GAP_EN). All outputs registered.
- Priority per edge: stop > pause > start.
- stop: any state -> IDLE; note_to_play 0, position 0, counter 0, next edge.
- IDLE + start with song_length != 0 -> PLAY.
  - Same edge: position 0, counter 0, note_to_play <= song[0].
- IDLE + start with song_length == 0: ignored; stays IDLE.
- PLAY: counter counts 0..NOTE_TICKS-1; note held exactly NOTE_TICKS cycles.
  - At edge with counter == NOTE_TICKS-1 and position < len-1: position+1, counter 0, note_to_play <= song[position+1].
- Last note (position == len-1, counter == NOTE_TICKS-1):
  - loop_en=1: position 0, note_to_play <= song[0], stay PLAY.
  - loop_en=0: -> IDLE, note_to_play 0, position 0, done=1 for exactly one cycle.
- len = min(song_length, SONG_LEN); song_length is sampled at start and held for the whole song.
- loop_en and song_packed are read live. A song_packed change takes effect at the next note load.
- PLAY + pause -> PAUSE: counter and position frozen, note_to_play 0 (rest), playing 0.
- PAUSE + start (pause low) -> PLAY: note_to_play <= song[position], counter resumes from its frozen value.
- start while in PLAY: no effect. pause while in IDLE: no effect.
- Mid-operation rst_n assertion: immediate return to reset values; no done pulse.

Optional Feature:
NOTE_GAP_EN
- Defined: after each note's NOTE_TICKS, enter GAP; note_to_play 0 for GAP_TICKS cycles, then load the next note.
  - GAP also runs before a loop restart.
  - No GAP before done: done fires at the last note's end, as without the macro.
  - pause and stop are honoured in GAP; resuming from a pause taken in GAP returns to GAP.
- Undefined: no GAP state; notes are back-to-back.

Test Plan (NOTE_W=4, SONG_LEN=4, NOTE_TICKS=4, POS_W=3, song = {0x4,0x3,0x2,0x1} with note0=0x1):
1. rst_n low mid-play -> next cycle note_to_play=0, position=0, playing=0; start one cycle after release -> note 0x1.
2. song_length=3, loop_en=0, pulse start -> notes 0x1,0x2,0x3 each held 4 cycles; then done=1 for 1 cycle, note_to_play=0, IDLE.
3. song_length=4, loop_en=1 -> sequence 0x1,0x2,0x3,0x4,0x1,... with no rest between 0x4 and 0x1; done never asserts.
4. Pause 2 cycles into note 0x2 for 10 cycles, then start -> note_to_play=0 during pause; 0x2 then held 2 more cycles, position=1 throughout.
5. stop and start asserted together during PLAY -> IDLE, note_to_play=0. song_length=0 with start -> stays IDLE. song_length=7 -> plays 4 notes.
6. NOTE_GAP_EN with GAP_TICKS=2 -> 0x1 x4 cycles, 0 x2, 0x2 x4, ...; with loop_en=0, done fires at the end of the last note with no trailing gap.

Source files
------------

// File: rtl/song_sequencer.sv
// Auto-play note sequencer: steps through a packed song and drives the buzzer note code.
// Define NOTE_GAP_EN to insert GAP_TICKS of rest between consecutive notes.
module song_sequencer #(
  parameter int NOTE_W     = 4,
  parameter int SONG_LEN   = 28,
  parameter int NOTE_TICKS = 500000,
  parameter int POS_W      = 5,
  parameter int GAP_TICKS  = 50000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       pause,
  input  logic                       stop,
  input  logic                       loop_en,
  input  logic [POS_W-1:0]           song_length,
  input  logic [NOTE_W*SONG_LEN-1:0] song_packed,
  output logic [NOTE_W-1:0]          note_to_play,
  output logic [POS_W-1:0]           position,
  output logic                       playing,
  output logic                       done
);

  localparam int MAX_TICKS = (NOTE_TICKS > GAP_TICKS) ? NOTE_TICKS : GAP_TICKS;
  localparam int CNT_W     = $clog2(MAX_TICKS);
  localparam int DEPTH     = 2 ** POS_W;
  localparam logic [CNT_W-1:0] NOTE_LAST = CNT_W'(NOTE_TICKS - 1);
  localparam logic [POS_W-1:0] MAX_LEN   = POS_W'(SONG_LEN);
`ifdef NOTE_GAP_EN
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_TICKS - 1);
`endif

  typedef enum logic [1:0] {IDLE, PLAY, PAUSE, GAP} state_t;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [POS_W-1:0]   pos_reg, pos_next;
  logic [POS_W-1:0]   len_reg, len_next;
  logic [NOTE_W-1:0]  note_reg, note_next;
  logic               playing_reg, playing_next;
  logic               done_reg, done_next;
`ifdef NOTE_GAP_EN
  logic               paused_gap_reg, paused_gap_next;
`endif

  // Index space padded to a power of two so position indexes it without width games.
  logic [NOTE_W-1:0] song_arr [DEPTH];
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_song
      if (gi < SONG_LEN) begin : g_note
        assign song_arr[gi] = song_packed[NOTE_W*gi +: NOTE_W];
      end else begin : g_pad
        assign song_arr[gi] = '0;
      end
    end
  endgenerate

  logic             at_last;
  logic [POS_W-1:0] next_pos;
  logic [POS_W-1:0] clamped_len;

  assign at_last     = (pos_reg == len_reg - POS_W'(1));
  assign next_pos    = at_last ? '0 : pos_reg + POS_W'(1);
  assign clamped_len = (song_length > MAX_LEN) ? MAX_LEN : song_length;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      pos_reg        <= '0;
      len_reg        <= '0;
      note_reg       <= '0;
      playing_reg    <= 1'b0;
      done_reg       <= 1'b0;
`ifdef NOTE_GAP_EN
      paused_gap_reg <= 1'b0;
`endif
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      pos_reg        <= pos_next;
      len_reg        <= len_next;
      note_reg       <= note_next;
      playing_reg    <= playing_next;
      done_reg       <= done_next;
`ifdef NOTE_GAP_EN
      paused_gap_reg <= paused_gap_next;
`endif
    end
  end

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    pos_next        = pos_reg;
    len_next        = len_reg;
    note_next       = note_reg;
    playing_next    = playing_reg;
    done_next       = 1'b0;
`ifdef NOTE_GAP_EN
    paused_gap_next = paused_gap_reg;
`endif
    if (stop) begin
      state_next   = IDLE;
      cnt_next     = '0;
      pos_next     = '0;
      note_next    = '0;
      playing_next = 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start && song_length != '0) begin
            state_next   = PLAY;
            len_next     = clamped_len;
            cnt_next     = '0;
            pos_next     = '0;
            note_next    = song_arr[0];
            playing_next = 1'b1;
          end
        end
        PLAY: begin
          if (pause) begin
            // The cycle just elapsed is credited so the note totals NOTE_TICKS across a pause.
            state_next   = PAUSE;
            cnt_next     = (cnt_reg == NOTE_LAST) ? cnt_reg : cnt_reg + CNT_W'(1);
            note_next    = '0;
            playing_next = 1'b0;
`ifdef NOTE_GAP_EN
            paused_gap_next = 1'b0;
`endif
          end else if (cnt_reg == NOTE_LAST) begin
            cnt_next = '0;
            if (at_last && !loop_en) begin
              state_next   = IDLE;
              pos_next     = '0;
              note_next    = '0;
              playing_next = 1'b0;
              done_next    = 1'b1;
            end else begin
`ifdef NOTE_GAP_EN
              state_next = GAP;
              note_next  = '0;
`else
              pos_next   = next_pos;
              note_next  = song_arr[next_pos];
`endif
            end
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
`ifdef NOTE_GAP_EN
        GAP: begin
          if (pause) begin
            state_next      = PAUSE;
            cnt_next        = (cnt_reg == GAP_LAST) ? cnt_reg : cnt_reg + CNT_W'(1);
            playing_next    = 1'b0;
            paused_gap_next = 1'b1;
          end else if (cnt_reg == GAP_LAST) begin
            state_next = PLAY;
            cnt_next   = '0;
            pos_next   = next_pos;
            note_next  = song_arr[next_pos];
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
`endif
        PAUSE: begin
          if (start && !pause) begin
            playing_next = 1'b1;
`ifdef NOTE_GAP_EN
            if (paused_gap_reg) begin
              state_next = GAP;
            end else begin
              state_next = PLAY;
              note_next  = song_arr[pos_reg];
            end
`else
            state_next = PLAY;
            note_next  = song_arr[pos_reg];
`endif
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign note_to_play = note_reg;
  assign position     = pos_reg;
  assign playing      = playing_reg;
  assign done         = done_reg;

endmodule
